// File: rtl/npu_mem_pkg.sv
// rtl/npu_mem_pkg.sv - shared scratch-memory widths, tile reader state and command types
package npu_mem_pkg;

  localparam int MEM_ADDR_W = 13;
  localparam int MEM_DATA_W = 8;
  localparam int TILE_DIM_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } tile_rd_state_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] base_addr;
    logic [TILE_DIM_W-1:0] rows;
    logic [TILE_DIM_W-1:0] cols;
    logic [MEM_ADDR_W-1:0] stride;
  } tile_cmd_t;

endpackage

// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - tile element counters and registered scratch address (MATRIX_TILE_READER_TRANSPOSE_EN adds column-major walk)
module tile_addr_gen
  import npu_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  tile_cmd_t         cmd,
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
  input  logic              transpose,
`endif
  input  logic              prime,
  input  logic              advance,
  output logic              addr_ok,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              eol,
  output logic              last
);

  // Inner/outer are c/r in row-major order and r/c when transposed; the
  // orientation is resolved once at load so the walk itself is identical.
  logic [TILE_DIM_W-1:0] in_lim;
  logic [TILE_DIM_W-1:0] out_lim;
  logic [TILE_DIM_W-1:0] in_cnt;
  logic [TILE_DIM_W-1:0] out_cnt;
  logic [ADDR_W-1:0]     in_step;
  logic [ADDR_W-1:0]     out_step;
  logic [ADDR_W-1:0]     line_base;

  // Position flags describe the element currently presented on mem_addr.
  always_comb begin
    eol  = (in_cnt == in_lim - 1'b1);
    last = eol && (out_cnt == out_lim - 1'b1);
  end

  // Counter/address walk: load the command, prime the first address, then step per accepted element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_lim    <= '0;
      out_lim   <= '0;
      in_step   <= '0;
      out_step  <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      line_base <= '0;
      mem_addr  <= '0;
      addr_ok   <= 1'b0;
    end else if (load) begin
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
      if (transpose) begin
        in_lim   <= cmd.rows;
        out_lim  <= cmd.cols;
        in_step  <= cmd.stride;
        out_step <= ADDR_W'(1);
      end else
`endif
      begin
        in_lim   <= cmd.cols;
        out_lim  <= cmd.rows;
        in_step  <= ADDR_W'(1);
        out_step <= cmd.stride;
      end
      in_cnt    <= '0;
      out_cnt   <= '0;
      line_base <= cmd.base_addr;
      addr_ok   <= 1'b0;
    end else if (prime) begin
      mem_addr <= line_base;
      addr_ok  <= 1'b1;
    end else if (advance) begin
      if (eol) begin
        in_cnt    <= '0;
        out_cnt   <= out_cnt + 1'b1;
        line_base <= line_base + out_step;
        mem_addr  <= line_base + out_step;
      end else begin
        in_cnt   <= in_cnt + 1'b1;
        mem_addr <= mem_addr + in_step;
      end
    end
  end

endmodule

// File: rtl/matrix_tile_reader.sv
// rtl/matrix_tile_reader.sv - walks a strided tile of scratch memory into a byte stream (MATRIX_TILE_READER_TRANSPOSE_EN adds transpose)
module matrix_tile_reader
  import npu_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DIM_W  = TILE_DIM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic [ADDR_W-1:0] stride,
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
  input  logic              transpose,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  tile_rd_state_t state;
  tile_rd_state_t state_nxt;
  tile_cmd_t      cmd;
  logic           load;
  logic           prime;
  logic           advance;
  logic           addr_ok;
  logic           elem_eol;
  logic           elem_last;

  assign cmd  = '{base_addr: base_addr, rows: rows, cols: cols, stride: stride};
  assign load = (state == IDLE) && start;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  tile_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .cmd       (cmd),
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
    .transpose (transpose),
`endif
    .prime     (prime),
    .advance   (advance),
    .addr_ok   (addr_ok),
    .mem_addr  (mem_addr),
    .eol       (elem_eol),
    .last      (elem_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the prime/advance strobes; the first RUN cycle only registers the address.
  always_comb begin
    state_nxt = state;
    prime     = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (rows == '0 || cols == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!addr_ok) begin
          prime = 1'b1;
        end else if (!out_valid || out_ready) begin
          advance = 1'b1;
          if (elem_last) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output beat register: captures memory data on advance, empties once the final beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_last  <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      out_data  <= mem_data;
      out_eol   <= elem_eol;
      out_last  <= elem_last;
    end else if (state == DRAIN && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_tile_reader.sv
// tb/tb_matrix_tile_reader.sv - table-driven scoreboard bench for matrix_tile_reader
module tb_matrix_tile_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] base_addr = '0;
  logic [7:0]  rows = '0;
  logic [7:0]  cols = '0;
  logic [12:0] stride = '0;
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
  logic        transpose = 1'b0;
`endif
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_eol;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:8191];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int base;
    int rows;
    int cols;
    int stride;
    bit tr;
    int mode;
    bit poke;
    int nbeats;
  } tvec_t;

  typedef struct {
    logic [7:0] data;
    logic       eol;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  tvec_t vecs[$];

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  matrix_tile_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .rows      (rows),
    .cols      (cols),
    .stride    (stride),
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
    .transpose (transpose),
`endif
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eol   (out_eol),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(exp));
  endtask

  function automatic tvec_t mk(input int base, input int r, input int c, input int s,
                               input bit tr, input int mode, input bit poke, input int nb);
    tvec_t v;
    v.base = base; v.rows = r; v.cols = c; v.stride = s;
    v.tr = tr; v.mode = mode; v.poke = poke; v.nbeats = nb;
    return v;
  endfunction

  function automatic beat_t mk_beat(input int base, input int stride, input int r, input int c,
                                    input bit eol, input bit last);
    beat_t b;
    int a;
    a = (base + r * stride + c) % 8192;
    b.data = 8'(a);
    b.eol  = eol;
    b.last = last;
    return b;
  endfunction

  task automatic run_tile(input tvec_t v, input string tag);
    int first_valid = -1;
    int done_n = -1;
    int done_cnt = 0;
    int nbeats = 0;
    int last_hs = -1;
    logic pv = 1'b0, pr = 1'b0, rdy, pe = 1'b0, pl = 1'b0;
    logic [7:0] pd = '0;
    beat_t e;
    exp_q.delete();
    if (!v.tr) begin
      for (int r = 0; r < v.rows; r++)
        for (int c = 0; c < v.cols; c++)
          exp_q.push_back(mk_beat(v.base, v.stride, r, c, c == v.cols - 1,
                                  (c == v.cols - 1) && (r == v.rows - 1)));
    end else begin
      for (int c = 0; c < v.cols; c++)
        for (int r = 0; r < v.rows; r++)
          exp_q.push_back(mk_beat(v.base, v.stride, r, c, r == v.rows - 1,
                                  (r == v.rows - 1) && (c == v.cols - 1)));
    end
    @(negedge clk);
    base_addr = 13'(v.base);
    rows      = 8'(v.rows);
    cols      = 8'(v.cols);
    stride    = 13'(v.stride);
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
    transpose = v.tr;
`endif
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 13'($urandom);
    rows      = 8'($urandom);
    cols      = 8'($urandom);
    stride    = 13'($urandom);
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
    transpose = ~transpose;
`endif
    for (int n = 0; n < 600; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      if (v.poke && n == 3) begin
        start = 1'b1; rows = 8'd7; cols = 8'd7; base_addr = 13'd4000;
      end
      if (v.poke && n == 4) start = 1'b0;
      if (out_valid && first_valid < 0) first_valid = n;
      if (pv && !pr) begin
        check({tag, "_stall_valid_held"}, 32'(out_valid), 32'd1);
        check({tag, "_stall_data"}, 32'(out_data), 32'(pd));
        check({tag, "_stall_eol"}, 32'(out_eol), 32'(pe));
        check({tag, "_stall_last"}, 32'(out_last), 32'(pl));
      end
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (done_n >= 0 && n >= done_n + 2) break;
      case (v.mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 4 == 0) || (n % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_beat"}, 32'(nbeats + 1), 32'(v.nbeats));
        end else begin
          e = exp_q.pop_front();
          check({tag, "_data"}, 32'(out_data), 32'(e.data));
          check({tag, "_eol"}, 32'(out_eol), 32'(e.eol));
          check({tag, "_last"}, 32'(out_last), 32'(e.last));
        end
        nbeats++;
        last_hs = n;
      end
      pv = out_valid; pr = rdy; pd = out_data; pe = out_eol; pl = out_last;
    end
    check({tag, "_done_seen"}, 32'(done_n >= 0), 32'd1);
    check({tag, "_beat_count"}, 32'(nbeats), 32'(v.nbeats));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_first_valid_cycle"}, 32'(first_valid), (v.nbeats > 0) ? 32'd2 : 32'hFFFF_FFFF);
    check({tag, "_done_cycle"}, 32'(done_n), (v.nbeats > 0) ? 32'(last_hs + 1) : 32'd0);
    check({tag, "_done_width"}, 32'(done_cnt), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int hs;
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i);

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_eol", 32'(out_eol), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    vecs.push_back(mk(16, 2, 3, 8, 0, 0, 0, 6));
    vecs.push_back(mk(16, 2, 3, 8, 0, 1, 1, 6));
    vecs.push_back(mk(8190, 1, 4, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 5, 1, 0, 0, 0, 0));
    vecs.push_back(mk(40, 3, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(100, 3, 2, 8191, 0, 2, 0, 6));
    vecs.push_back(mk(7, 1, 1, 0, 0, 0, 0, 1));
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
    vecs.push_back(mk(0, 2, 2, 4, 1, 0, 0, 4));
    vecs.push_back(mk(8000, 3, 2, 200, 1, 1, 0, 6));
`endif
    for (int i = 0; i < vecs.size(); i++) run_tile(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a tile after three accepted beats.
    @(negedge clk);
    base_addr = 13'd0; rows = 8'd4; cols = 8'd4; stride = 13'd16;
`ifdef MATRIX_TILE_READER_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int n = 0; n < 50 && hs < 3; n++) begin
      @(negedge clk);
      if (out_valid) hs++;
    end
    check("midrst_three_beats", 32'(hs), 32'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_eol", 32'(out_eol), 32'd0);
    check("midrst_last", 32'(out_last), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_no_done", 32'(done), 32'd0);
    check("postrst_no_valid", 32'(out_valid), 32'd0);
    run_tile(mk(0, 1, 1, 0, 0, 0, 0, 1), "postrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
